branch_predict_tracker: RTL

BRANCH_PREDICT_TRACKER -- requirements
Module: branch_predict_tracker

---
 rtl/branch_predict_tracker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_predict_tracker.sv
// In-flight conditional-branch tracker: FIFO of {idx, pred}, registered BHT update strobe and mispredict flush.
// Optional macro BPT_STATS_EN adds saturating resolve/mispredict counters.
module branch_predict_tracker #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic              fetch_is_branch,
    input  logic [ADDR_W-1:0] fetch_idx,
    input  logic              fetch_pred,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              fetch_stall,
    output logic              bht_write_en,
    output logic [ADDR_W-1:0] bht_write_addr,
    output logic              bht_was_taken,
    output logic              mispredict,
`ifdef BPT_STATS_EN
    output logic [15:0]       stat_resolved,
    output logic [15:0]       stat_mispredicts,
`endif
    output logic              underflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] idx_mem_q [DEPTH];
    logic [DEPTH-1:0]  pred_mem_q;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              was_taken_q;
    logic              mispredict_q;
    logic              underflow_q;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mis;
    logic              head_pred;
    logic [ADDR_W-1:0] head_idx;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign push      = fetch_valid & fetch_is_branch & ~full;
    assign pop       = resolve_valid & ~empty;
    assign head_pred = pred_mem_q[head_q];
    assign head_idx  = idx_mem_q[head_q];
    assign mis       = pop & (head_pred != resolve_taken);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mis) begin
            // Flush drops every in-flight entry, including a push arriving this cycle.
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            was_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            wr_en_q      <= pop;
            mispredict_q <= mis;
            if (pop) begin
                wr_addr_q   <= head_idx;
                was_taken_q <= resolve_taken;
            end
            if (resolve_valid && empty)
                underflow_q <= 1'b1;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !mis) begin
            idx_mem_q[tail_q]  <= fetch_idx;
            pred_mem_q[tail_q] <= fetch_pred;
        end
    end

`ifdef BPT_STATS_EN
    logic [15:0] stat_res_q;
    logic [15:0] stat_mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && stat_res_q != 16'hFFFF)
                stat_res_q <= stat_res_q + 16'd1;
            if (mis && stat_mis_q != 16'hFFFF)
                stat_mis_q <= stat_mis_q + 16'd1;
        end
    end

    assign stat_resolved    = stat_res_q;
    assign stat_mispredicts = stat_mis_q;
`endif

    assign fetch_stall    = full;
    assign bht_write_en   = wr_en_q;
    assign bht_write_addr = wr_addr_q;
    assign bht_was_taken  = was_taken_q;
    assign mispredict     = mispredict_q;
    assign underflow_err  = underflow_q;

endmodule
